// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan readback path: active-low
// segment codes, controller states, per-slot pattern classes and the frame type.
package seg7_pkg;

   localparam int NUM_SLOTS = 4;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;

   typedef enum logic [1:0] {COLLECT, CHECK, CONVERT, DONE} state_t;
   typedef enum logic [1:0] {DIGIT, BLANK, MINUS, ILLEGAL} seg_class_t;

   // Index 0 is the rightmost digit, index 3 carries the optional sign.
   typedef logic [NUM_SLOTS-1:0][6:0] frame_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Classifies one active-low segment pattern and returns its decimal digit.
// Blank and minus both read as digit 0; minus is only legal in the sign slot.
module seg7_to_bcd
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   input  logic       is_slot3,
   output logic [3:0] bcd,
   output seg_class_t cls
);

   // NOTE: every output gets a default before the case so no path infers a latch.
   always_comb begin
      bcd = 4'd0;
      cls = DIGIT;
      case (seg)
         SEG_0:     bcd = 4'd0;
         SEG_1:     bcd = 4'd1;
         SEG_2:     bcd = 4'd2;
         SEG_3:     bcd = 4'd3;
         SEG_4:     bcd = 4'd4;
         SEG_5:     bcd = 4'd5;
         SEG_6:     bcd = 4'd6;
         SEG_7:     bcd = 4'd7;
         SEG_8:     bcd = 4'd8;
         SEG_9:     bcd = 4'd9;
         SEG_BLANK: cls = BLANK;
         SEG_MINUS: cls = is_slot3 ? MINUS : ILLEGAL;
         default:   cls = ILLEGAL;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the four displayed characters from the multiplexed segment scan,
// waits for a stable display and converts it to a signed value with a valid pulse.
module seg_scan_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_FRAMES = 2,
   parameter int MATCH_W       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg,
   input  logic [1:0]  refreshcounter,
   input  logic        sample_en,
   output logic [13:0] value,
   output logic        negative,
   output logic        valid,
   output logic        err,
   output logic        busy
);

   localparam logic [MATCH_W-1:0] MATCH_TARGET = MATCH_W'(STABLE_FRAMES);

   state_t               state, state_next;
   frame_t               slot, frame, prev_frame, last_emitted;
   logic [NUM_SLOTS-1:0] seen;
   logic                 last_emitted_ok;
   logic [MATCH_W-1:0]   match, match_next;
   logic [13:0]          acc, acc_step;
   logic                 neg_next;
   logic [1:0]           digit_idx;
   logic                 frame_done, frame_illegal, same_as_prev, already_emitted;
   logic [3:0]           bcd [NUM_SLOTS];
   seg_class_t           cls [NUM_SLOTS];

   assign frame_done = (seen == '1);

   // Slot capture runs in every state; a completed frame clears seen even when
   // the controller is busy and the frame is dropped.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot <= {NUM_SLOTS{SEG_BLANK}};
         seen <= '0;
      end else begin
         if (sample_en)
            slot[refreshcounter] <= seg;
         seen <= (frame_done ? '0 : seen) | (sample_en ? (4'b0001 << refreshcounter) : '0);
      end
   end

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      seg7_to_bcd u_dec (
         .seg      (frame[i]),
         .is_slot3 (i == NUM_SLOTS - 1),
         .bcd      (bcd[i]),
         .cls      (cls[i])
      );
   end

   always_comb begin
      frame_illegal = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++)
         if (cls[i] == ILLEGAL)
            frame_illegal = 1'b1;
   end

   assign same_as_prev    = (frame == prev_frame);
   assign already_emitted = last_emitted_ok && (frame == last_emitted);

   // acc*10 + d; the sum never exceeds 9999 so the 14-bit result is exact.
   assign acc_step = (acc << 3) + (acc << 1) + {10'd0, bcd[digit_idx]};

   always_comb begin
      state_next = state;
      match_next = match;
      case (state)
         COLLECT: begin
            if (frame_done)
               state_next = CHECK;
         end
         CHECK: begin
            state_next = COLLECT;
            if (frame_illegal) begin
               match_next = '0;
            end else begin
               if (!same_as_prev)
                  match_next = {{(MATCH_W-1){1'b0}}, 1'b1};
               else if (match >= MATCH_TARGET)
                  match_next = MATCH_TARGET;
               else
                  match_next = match + 1'b1;
               if (match_next == MATCH_TARGET && !already_emitted)
                  state_next = CONVERT;
            end
         end
         CONVERT: begin
            if (digit_idx == 2'd0)
               state_next = DONE;
         end
         DONE:    state_next = COLLECT;
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= COLLECT;
         match           <= '0;
         frame           <= {NUM_SLOTS{SEG_BLANK}};
         prev_frame      <= {NUM_SLOTS{SEG_BLANK}};
         last_emitted    <= {NUM_SLOTS{SEG_BLANK}};
         last_emitted_ok <= 1'b0;
         acc             <= '0;
         neg_next        <= 1'b0;
         digit_idx       <= '0;
         value           <= '0;
         negative        <= 1'b0;
      end else begin
         state <= state_next;
         match <= match_next;
         case (state)
            COLLECT: begin
               if (frame_done)
                  frame <= slot;
            end
            CHECK: begin
               prev_frame <= frame;
               acc        <= '0;
               neg_next   <= 1'b0;
               digit_idx  <= 2'd3;
            end
            CONVERT: begin
               acc       <= acc_step;
               digit_idx <= digit_idx - 2'd1;
               if (cls[digit_idx] == MINUS)
                  neg_next <= 1'b1;
               // Load the result on the final step so it is visible with valid.
               if (digit_idx == 2'd0) begin
                  value    <= acc_step;
                  negative <= neg_next;
               end
            end
            DONE: begin
               last_emitted    <= frame;
               last_emitted_ok <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign valid = (state == DONE);
   assign err   = (state == CHECK) && frame_illegal;
   assign busy  = (state != COLLECT);

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reader for the multiplexed seven-segment scan stream that the display controller drives: the segment pattern and the refresh slot index.
- Samples each slot and rebuilds the four displayed characters.
- Checks that the displayed frame has been stable for a set number of full scans, then converts the digits to a signed binary value with a one-cycle valid pulse.
- Used as a self-check/readback path for calculator results and as a bench monitor.

Parameters:
- STABLE_FRAMES, 2, number of consecutive identical complete frames required before conversion (range 1..15).
- MATCH_W, 4, width of the match counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- seg  input  7  segment pattern {g,f,e,d,c,b,a}, active-low
- refreshcounter  input  2  slot index of current pattern (0 = rightmost digit)
- sample_en  input  1  one-cycle strobe; seg/refreshcounter are stable and must be captured this cycle
- value  output  14  magnitude of displayed number, 0..9999
- negative  output  1  minus sign present in slot 3
- valid  output  1  one-cycle pulse when value/negative are updated
- err  output  1  one-cycle pulse when a complete frame contains an illegal pattern
- busy  output  1  high in CHECK/CONVERT/DONE

Behaviour:
- Reset (async): all slot registers 7'h7F, seen=0, match=0, value=0, negative=0, valid=0, err=0, busy=0, state=COLLECT, last_emitted invalid.
- Pattern classes (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex); blank=7F; minus=3F.
  - Minus is legal only in slot 3. Any other code, or minus in slots 0-2, is illegal.
- Collection (all states): on sample_en, slot[refreshcounter] <= seg and seen[refreshcounter] <= 1.
  - A repeated slot before frame completion overwrites the stored pattern; seen is unchanged.
- Frame complete: seen==4'b1111 at the clock edge. In that cycle:
  - Snapshot slots into frame.
  - Clear seen. If sample_en is also active that cycle, the new sample sets its seen bit after the clear.
  - Go to CHECK, but only if state is COLLECT. Otherwise the frame is discarded.
- CHECK (1 cycle):
  - If any slot is illegal: err=1 for this cycle, match=0, prev_frame<=frame, return to COLLECT.
  - If frame==prev_frame: match saturates up at STABLE_FRAMES. Otherwise match=1 and prev_frame<=frame.
  - If match (post-update) == STABLE_FRAMES and frame != last_emitted: go to CONVERT. Otherwise go to COLLECT.
- CONVERT (exactly 4 cycles, slot 3 down to 0): acc <= acc*10 + d, with acc cleared on entry.
  - acc*10 is formed as (acc<<3)+(acc<<1), 17-bit intermediate, truncated to 14 bits. Truncation is lossless because the maximum is 9999.
  - Blank counts as digit 0. Minus counts as digit 0 and sets neg_next.
- DONE (1 cycle): value<=acc, negative<=neg_next, valid=1, last_emitted<=frame, then go to COLLECT.
- Latency: valid is asserted 6 cycles after the frame-complete edge (CHECK 1 + CONVERT 4 + DONE 1).
- A stable unchanged display never produces a second valid. A changed display must again reach STABLE_FRAMES identical frames.
- valid and err are never high in the same cycle; both are single-cycle pulses.
- value and negative hold between valid pulses.
- rst asserted mid-CONVERT aborts the conversion with no valid; all state is cleared as in reset.

Decomposition:
- Package seg7_pkg: segment code constants (SEG_0..SEG_9, SEG_BLANK, SEG_MINUS), state enumeration (COLLECT, CHECK, CONVERT, DONE), class encoding (DIGIT, BLANK, MINUS, ILLEGAL).
- Sub-module seg7_to_bcd: combinational; seg[6:0] + is_slot3 -> bcd[3:0], class[1:0]. Instantiate it once per slot on the frame snapshot.

Test Plan:
- Scan "1234" (slot3..0 = 79,24,30,19) for 2 full frames, STABLE_FRAMES=2 -> valid pulse once, value=1234, negative=0, 6 cycles after the second frame's last sample. A third identical frame -> no valid.
- Scan slot3=3F, slots 2..0 = 7F,30,40 for 2 frames -> valid, value=30, negative=1.
- Scan one frame containing 7'h55 in slot1 -> err pulse in the CHECK cycle, no valid, match reset. Then 2 good frames of "0009" -> value=9.
- Alternating frames "1111"/"1112" for 6 frames -> no valid. Then "1112" twice in a row -> valid, value=1112.
- Slot 2 sampled twice (24, then 30) before slots 0, 1, 3 arrive -> the frame uses 30 for slot 2.
- rst pulsed during the 2nd CONVERT cycle -> valid stays 0, value=0. Two fresh frames of "9999" -> value=9999, negative=0.
